// File: rtl/coeff_decomposer.sv
// coeff_decomposer: two-stage Decompose (r = r1*alpha + r0 mod q) for the
// Dilithium hint/high-bits path. Stage 1 reduces the input mod q and finds r1.
// Stage 2 applies the wrap rule and forms r0 mod q.
//
// Handshake: a coefficient is taken on an edge where valid_i && ready_i.
// A result is handed off on an edge where valid_o && ready_o. ready_i is
// en = !valid_o || ready_o, gated low while rst is asserted. Every stage
// advances only when en is high, so a stall freezes the whole pipe and
// nothing is lost or duplicated.
module coeff_decomposer #(
  parameter int COEFF_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         sec_lvl,
  input  logic               valid_i,
  output logic               ready_i,
  input  logic [COEFF_W-1:0] di,
  output logic [COEFF_W-1:0] doa,
  output logic [COEFF_W-1:0] dob,
  output logic               valid_o,
  input  logic               ready_o
);

  localparam int W = COEFF_W;
  localparam logic [W-1:0] Q        = W'(8380417);
  localparam logic [W-1:0] ALPHA_88 = W'(190464);
  localparam logic [W-1:0] G2_88    = W'(95232);
  localparam logic [W-1:0] ALPHA_32 = W'(523776);
  localparam logic [W-1:0] G2_32    = W'(261888);

  logic         en;
  logic [W-1:0] red_a, red_r, in_alpha, in_g2;
  logic [W:0]   t_val;
  logic [5:0]   in_r1;
  logic         sel_88;

  logic         s1_valid;
  logic [W-1:0] s1_r, s1_alpha;
  logic [5:0]   s1_r1;

  logic [5:0]   wrap_lim;
  logic [W:0]   prod, diff, diff_q;
  logic [W-1:0] nxt_doa, nxt_dob;

  assign en      = !valid_o || ready_o;
  assign ready_i = rst && en;

  // Stage 1 logic: reduce mod q (two subtractions cover 2^24-1 < 3q), pick
  // alpha/gamma2 and count how many multiples of alpha lie at or below
  // r + gamma2 - 1, which is exactly floor((r + gamma2 - 1) / alpha).
  always_comb begin
    red_a    = (di >= Q) ? di - Q : di;
    red_r    = (red_a >= Q) ? red_a - Q : red_a;
    sel_88   = (sec_lvl == 3'b010);
    in_alpha = sel_88 ? ALPHA_88 : ALPHA_32;
    in_g2    = sel_88 ? G2_88 : G2_32;
    t_val    = {1'b0, red_r} + {1'b0, in_g2} - (W+1)'(1);
    in_r1    = '0;
    for (int k = 1; k <= 44; k++) begin
      if (sel_88 && (t_val >= (W+1)'(k * 190464))) in_r1 = in_r1 + 6'd1;
    end
    for (int k = 1; k <= 16; k++) begin
      if (!sel_88 && (t_val >= (W+1)'(k * 523776))) in_r1 = in_r1 + 6'd1;
    end
  end

  // Stage 1 register: holds reduced r, alpha and r1 while the pipe is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_alpha <= '0;
      s1_r1    <= '0;
    end else if (en) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_r     <= red_r;
        s1_alpha <= in_alpha;
        s1_r1    <= in_r1;
      end
    end
  end

  // Stage 2 logic: r1 == (q-1)/alpha folds to r1 = 0, r0 = r - q (so dob = r);
  // otherwise r0 = r - r1*alpha with a guard bit, mapped to q + r0 if negative.
  always_comb begin
    wrap_lim = (s1_alpha == ALPHA_88) ? 6'd44 : 6'd16;
    prod     = (W+1)'(s1_r1) * {1'b0, s1_alpha};
    diff     = {1'b0, s1_r} - prod;
    diff_q   = diff + {1'b0, Q};
    nxt_doa  = W'(s1_r1);
    nxt_dob  = diff[W] ? diff_q[W-1:0] : diff[W-1:0];
    if (s1_r1 == wrap_lim) begin
      nxt_doa = '0;
      nxt_dob = s1_r;
    end
  end

  // Stage 2 register: the output holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o <= 1'b0;
      doa     <= '0;
      dob     <= '0;
    end else if (en) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        doa <= nxt_doa;
        dob <= nxt_dob;
      end
    end
  end

endmodule

// File: tb/tb_coeff_decomposer.sv
module tb_coeff_decomposer;

  localparam int Q = 8380417;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  sec_lvl = '0;
  logic        valid_i = 1'b0;
  logic        ready_i;
  logic [23:0] di = '0;
  logic [23:0] doa, dob;
  logic        valid_o;
  logic        ready_o = 1'b0;

  coeff_decomposer #(.COEFF_W(24)) dut (
    .clk(clk), .rst(rst), .sec_lvl(sec_lvl), .valid_i(valid_i),
    .ready_i(ready_i), .di(di), .doa(doa), .dob(dob),
    .valid_o(valid_o), .ready_o(ready_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // scoreboard
  logic [47:0] exp_q[$];
  logic [23:0] din_q[$];
  logic [2:0]  sel_q[$];
  int          cyc_q[$];

  // samples taken mid-cycle by the driver
  logic        s_vo, s_ri;
  logic [23:0] s_a, s_b;

  // reference: centered mod-alpha split of (di mod q), with the q-1 corner
  function automatic logic [47:0] model(input logic [23:0] d, input logic [2:0] sl);
    int r, alpha, g2, r0, r1, b;
    r     = int'(d) % Q;
    g2    = (sl == 3'b010) ? (Q - 1) / 88 : (Q - 1) / 32;
    alpha = 2 * g2;
    r0    = r % alpha;
    if (r0 > g2) r0 = r0 - alpha;
    if (r - r0 == Q - 1) begin
      r1 = 0;
      r0 = r0 - 1;
    end else begin
      r1 = (r - r0) / alpha;
    end
    b = (r0 < 0) ? r0 + Q : r0;
    return {24'(r1), 24'(b)};
  endfunction

  function automatic int gamma2(input logic [2:0] sl);
    return (sl == 3'b010) ? (Q - 1) / 88 : (Q - 1) / 32;
  endfunction

  // driver: apply inputs after the falling edge, sample, run one clock
  task automatic drive(input logic vi, input logic [23:0] d, input logic [2:0] sl,
                       input logic ro, output logic acc, output logic xfer);
    valid_i = vi; di = d; sec_lvl = sl; ready_o = ro;
    #1;
    s_vo = valid_o; s_ri = ready_i; s_a = doa; s_b = dob;
    acc  = vi && ready_i;
    xfer = valid_o && ro;
    if (acc) begin
      exp_q.push_back(model(d, sl));
      din_q.push_back(d);
      sel_q.push_back(sl);
      cyc_q.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_sb();
    exp_q.delete(); din_q.delete(); sel_q.delete(); cyc_q.delete();
  endtask

  task automatic test_reset();
    logic acc, xfer;
    rst = 1'b0;
    #3;
    total++;
    if (valid_o !== 1'b0 || doa !== 24'd0 || dob !== 24'd0 || ready_i !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: valid_o=%b doa=%0d dob=%0d ready_i=%b, want 0/0/0/0",
               valid_o, doa, dob, ready_i);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 24'd0, 3'd0, 1'b1, acc, xfer);
      total++;
      if (s_vo !== 1'b0 || s_ri !== 1'b1) begin
        bad++;
        $display("FAIL idle_%0d: valid_o=%b ready_i=%b, want 0/1", i, s_vo, s_ri);
      end
    end
  endtask

  logic [23:0] vec_di[9] = '{24'd2312250, 24'd2500010, 24'd8022100, 24'd2312250,
                             24'd8194721, 24'd0, 24'd8380416, 24'd9000000, 24'd16777215};
  logic [2:0]  vec_sl[9] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
  logic [23:0] vec_a[9]  = '{24'd4, 24'd5, 24'd15, 24'd12, 24'd43, 24'd0, 24'd0, 24'd3, 24'd0};
  logic [23:0] vec_b[9]  = '{24'd217146, 24'd8261547, 24'd165460, 24'd26682, 24'd4769,
                             24'd0, 24'd8380416, 24'd48191, 24'd16381};

  task automatic test_vectors();
    logic acc, xfer;
    int sent = 0, got = 0, c;
    clear_sb();
    for (int it = 0; it < 16; it++) begin
      if (sent < 9) drive(1'b1, vec_di[sent], vec_sl[sent], 1'b1, acc, xfer);
      else          drive(1'b0, 24'd0, 3'd0, 1'b1, acc, xfer);
      if (acc) sent++;
      if (xfer) begin
        c = cyc_q.pop_front();
        void'(exp_q.pop_front()); void'(din_q.pop_front()); void'(sel_q.pop_front());
        total++;
        if (got >= 9 || s_a !== vec_a[got] || s_b !== vec_b[got] || (cyc - 1) - c != 2) begin
          bad++;
          $display("FAIL vector_%0d: doa=%0d dob=%0d latency=%0d, want doa=%0d dob=%0d latency=2",
                   got, s_a, s_b, (cyc - 1) - c, (got < 9) ? vec_a[got] : 0,
                   (got < 9) ? vec_b[got] : 0);
        end
        got++;
      end
    end
    total++;
    if (got != 9) begin
      bad++;
      $display("FAIL vector_count: got %0d results, want 9", got);
    end
  endtask

  task automatic test_backpressure();
    logic acc, xfer, stall, snap_ok;
    logic [23:0] snap_a, snap_b, d;
    logic [47:0] e;
    int sent = 0, got = 0;
    clear_sb();
    snap_ok = 1'b0; snap_a = '0; snap_b = '0;
    for (int it = 0; it < 24; it++) begin
      stall = (it >= 3 && it < 8);
      d = 24'($urandom_range(0, 16777215));
      drive(sent < 4, d, 3'($urandom_range(0, 3)), !stall, acc, xfer);
      if (acc) sent++;
      if (stall) begin
        if (!snap_ok) begin
          snap_a = s_a; snap_b = s_b; snap_ok = 1'b1;
        end
        total++;
        if (s_vo !== 1'b1 || s_a !== snap_a || s_b !== snap_b || s_ri !== 1'b0 || acc) begin
          bad++;
          $display("FAIL stall_%0d: valid_o=%b doa=%0d dob=%0d ready_i=%b, want 1/%0d/%0d/0",
                   it, s_vo, s_a, s_b, s_ri, snap_a, snap_b);
        end
      end
      if (xfer) begin
        e = exp_q.pop_front();
        void'(din_q.pop_front()); void'(sel_q.pop_front()); void'(cyc_q.pop_front());
        total++;
        if ({s_a, s_b} !== e) begin
          bad++;
          $display("FAIL bp_result_%0d: doa=%0d dob=%0d, want %0d/%0d",
                   got, s_a, s_b, e[47:24], e[23:0]);
        end
        got++;
      end
    end
    total++;
    if (got != 4 || sent != 4 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_count: sent=%0d got=%0d left=%0d, want 4/4/0", sent, got, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic acc, xfer;
    logic [23:0] d, dd;
    logic [2:0] sl, ss;
    logic [47:0] e;
    int sent = 0, got = 0, budget = 0, g2, alpha, c0;
    longint chk;
    clear_sb();
    while (got < 1000 && budget < 8000) begin
      case ($urandom_range(0, 3))
        0: d = 24'($urandom_range(0, 16777215));
        1: d = 24'(Q - 3 + $urandom_range(0, 6));
        2: d = 24'($urandom_range(0, 300000));
        default: d = 24'($urandom_range(0, Q - 1));
      endcase
      sl = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'($urandom_range(0, 7));
      drive((sent < 1000) && ($urandom_range(0, 3) != 0), d, sl,
            $urandom_range(0, 9) < 7, acc, xfer);
      budget++;
      if (acc) sent++;
      total++;
      if (s_ri !== (!s_vo || ready_o)) begin
        bad++;
        $display("FAIL rnd_ready: ready_i=%b valid_o=%b ready_o=%b", s_ri, s_vo, ready_o);
      end
      if (xfer) begin
        e  = exp_q.pop_front();
        dd = din_q.pop_front();
        ss = sel_q.pop_front();
        void'(cyc_q.pop_front());
        total++;
        if ({s_a, s_b} !== e) begin
          bad++;
          $display("FAIL rnd_result_%0d: di=%0d sel=%0d doa=%0d dob=%0d, want %0d/%0d",
                   got, dd, ss, s_a, s_b, e[47:24], e[23:0]);
        end
        g2    = gamma2(ss);
        alpha = 2 * g2;
        c0    = (int'(s_b) > g2) ? int'(s_b) - Q : int'(s_b);
        chk   = (longint'(s_a) * alpha + c0 - longint'(dd)) % Q;
        total++;
        if (chk != 0 || c0 <= -g2 || c0 > g2) begin
          bad++;
          $display("FAIL rnd_identity_%0d: di=%0d r1=%0d r0=%0d residue=%0d gamma2=%0d",
                   got, dd, s_a, c0, chk, g2);
        end
        got++;
      end
    end
    total++;
    if (got != 1000) begin
      bad++;
      $display("FAIL rnd_timeout: got %0d of 1000 results", got);
    end
  endtask

  task automatic test_reset_mid();
    logic acc, xfer;
    clear_sb();
    for (int i = 0; i < 2; i++) drive(1'b1, 24'(1000000 + i), 3'd0, 1'b0, acc, xfer);
    drive(1'b1, 24'd2312250, 3'd2, 1'b0, acc, xfer);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b0 || doa !== 24'd0 || dob !== 24'd0 || ready_i !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: valid_o=%b doa=%0d dob=%0d ready_i=%b, want 0/0/0/0",
               valid_o, doa, dob, ready_i);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_sb();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 24'd0, 3'd0, 1'b1, acc, xfer);
      total++;
      if (s_vo !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_%0d: valid_o=%b, want 0", i, s_vo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
